mux_frame_sampler: RTL and testbench
====================================

// Module: mux_frame_sampler
// PURPOSE
//  Host-side partner of the mux channel switcher: generates its switch strobe, waits analog settling,
//  runs one ADC conversion per mux slot and assembles NCH samples into a frame. Ping-pong frame
//  buffer: the finished frame is readable while the next is collected. Sits between switcher, ADC and framer.
// PARAMETERS
//  NCH      18   slots per frame (switcher channel sequence length, 0..NCH-1)
//  DW       12   ADC sample width
//  SETTLE   64   clk cycles from mux change to adc_start
//  SW_HI    4    switch_out high time, cycles (>=2)
//  SW_LO    4    switch_out low time after high, cycles (>=2)
//  TMO      1024 max cycles waiting adc_done
// PORTS
//  clk          in   1     system clock
//  reset        in   1     asynchronous, active-low
//  enable       in   1     run acquisition; sampled in IDLE and at frame boundary only
//  switch_out   out  1     strobe to switcher; each high pulse advances mux one slot
//  adc_start    out  1     1-cycle conversion request
//  adc_done     in   1     1-cycle conversion complete, adc_data valid same cycle
//  adc_data     in   DW    sample
//  slot         out  5     slot currently being acquired
//  rd_addr      in   5     frame read address (0..NCH-1)
//  rd_data      out  DW    sample of last completed frame, registered, 1-cycle latency
//  frame_valid  out  1     1-cycle pulse: a frame completed and banks swapped
//  frame_cnt    out  16    completed frames, wraps 0xFFFF->0
//  timeout_err  out  1     sticky; set on any adc_done timeout, cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, slot=0, write bank=0, buffers not cleared (rd_data 0 until first frame).
//  States: IDLE -> SETTLE -> CONVERT -> STORE -> SW_HIGH -> SW_LOW -> SETTLE ...
//  IDLE: enable=1 -> SETTLE (slot=0, matches switcher reset channel 0).
//  SETTLE: count SETTLE cycles, then adc_start=1 for exactly one cycle on entry to CONVERT.
//  CONVERT: wait adc_done; capture adc_data. No done within TMO cycles of adc_start ->
//   capture 0, set timeout_err. adc_done outside CONVERT is ignored.
//  STORE: write sample to write bank[slot] (one cycle).
//  SW_HIGH: switch_out=1 for SW_HI cycles; SW_LOW: switch_out=0 for SW_LO cycles, then:
//   slot<NCH-1: slot+1 -> SETTLE.
//   slot==NCH-1: slot=0, swap banks, frame_valid pulse, frame_cnt+1; enable=1 -> SETTLE, else IDLE.
//  Switch pulse after last slot is always issued, so switcher wraps to channel 0 in step with slot=0.
//  Per-slot period = SETTLE+1+conv+1+SW_HI+SW_LO cycles.
//  Read: rd_data <= read bank[rd_addr] every cycle; rd_addr>=NCH returns 0.
//   Read during swap cycle returns old bank; new bank from next cycle.
//  enable deassert mid-frame: frame completes, then IDLE (no partial frames).
//  Reset mid-operation: async return to IDLE, switch_out drops immediately; partial frame discarded.
//  All counters sized $clog2(max+1); no arithmetic wider than 16 bits.
// STRUCTURE
//  Shared package mux_pkg: NCH default, state enum encoding, slot width constant (also used by switcher).
//  Sub-module mux_frame_buf: 2xNCHxDW ping-pong register array, write port, registered read, bank select.
//  Top holds FSM, SETTLE/SW/TMO shared down-counter, slot and frame counters.
// TESTING
//  Reset, enable=1, ADC model done after 10 cycles, data=0x100+slot -> frame_valid after 18 slots;
//   rd_addr 0..17 reads 0x100..0x111; frame_cnt=1; exactly 18 switch_out pulses.
//  Pair with switcher RTL: after each STORE, switcher channel == slot; after frame, channel==0.
//  ADC never answers on slot 5 -> adc_start-to-STORE = TMO cycles, slot 5 reads 0, timeout_err=1, frame completes.
//  Drop enable at slot 9 -> frame finishes, 1 frame_valid, IDLE, switch_out stays 0.
//  Read rd_addr=3 continuously across swap -> old value on swap cycle, new value the cycle after.
//  Assert reset at slot 7 during SW_HIGH -> switch_out 0 same cycle, frame_cnt=0, restart yields slot 0.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: constants and state encoding shared by the mux channel switcher and the frame sampler.
package mux_pkg;
    localparam int NCH = 18;
    localparam int SLOT_W = 5;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CONVERT,
        ST_STORE,
        ST_SW_HIGH,
        ST_SW_LOW
    } state_t;
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/mux_frame_buf.sv
// mux_frame_buf: ping-pong frame store, one bank written while the other is read with registered output.
module mux_frame_buf #(
    parameter int NCH = mux_pkg::NCH,
    parameter int DW  = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we,
    input  logic [mux_pkg::SLOT_W-1:0] wr_addr,
    input  logic [DW-1:0]              wr_data,
    input  logic                       swap,
    input  logic [mux_pkg::SLOT_W-1:0] rd_addr,
    output logic [DW-1:0]              rd_data
);
    import mux_pkg::*;
    logic [DW-1:0] mem [2][NCH];
    logic wr_bank;
    logic have_frame;
    always_ff @(posedge clk)
        if (we) mem[wr_bank][wr_addr] <= wr_data;
    // Storage is never cleared; have_frame hides it until the first completed frame.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wr_bank    <= 1'b0;
            have_frame <= 1'b0;
            rd_data    <= '0;
        end else begin
            if (swap) begin
                wr_bank    <= ~wr_bank;
                have_frame <= 1'b1;
            end
            rd_data <= (have_frame && rd_addr < SLOT_W'(NCH)) ? mem[~wr_bank][rd_addr] : '0;
        end
endmodule

// File: rtl/mux_frame_sampler.sv
// mux_frame_sampler: drives the mux switch strobe, waits settling, runs one ADC conversion per slot
// and assembles NCH samples into a ping-pong buffered frame.
module mux_frame_sampler #(
    parameter int NCH    = mux_pkg::NCH,
    parameter int DW     = 12,
    parameter int SETTLE = 64,
    parameter int SW_HI  = 4,
    parameter int SW_LO  = 4,
    parameter int TMO    = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    output logic                       switch_out,
    output logic                       adc_start,
    input  logic                       adc_done,
    input  logic [DW-1:0]              adc_data,
    output logic [mux_pkg::SLOT_W-1:0] slot,
    input  logic [mux_pkg::SLOT_W-1:0] rd_addr,
    output logic [DW-1:0]              rd_data,
    output logic                       frame_valid,
    output logic [15:0]                frame_cnt,
    output logic                       timeout_err
);
    import mux_pkg::*;
    localparam int CW = $clog2(max2(max2(SETTLE, TMO), max2(SW_HI, SW_LO)) + 1);
    state_t state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] sample;
    logic last;
    logic swap;
    assign last = slot == SLOT_W'(NCH - 1);
    assign swap = state == ST_SW_LOW && cnt == '0 && last;
    // One down-counter times settling, conversion timeout and both switch phases.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            slot        <= '0;
            sample      <= '0;
            switch_out  <= 1'b0;
            adc_start   <= 1'b0;
            frame_valid <= 1'b0;
            frame_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            adc_start   <= 1'b0;
            frame_valid <= 1'b0;
            case (state)
                ST_IDLE:
                    if (enable) begin
                        state <= ST_SETTLE;
                        slot  <= '0;
                        cnt   <= CW'(SETTLE - 1);
                    end
                ST_SETTLE:
                    if (cnt == '0) begin
                        state     <= ST_CONVERT;
                        adc_start <= 1'b1;
                        cnt       <= CW'(TMO - 1);
                    end else cnt <= cnt - 1'b1;
                ST_CONVERT:
                    if (adc_done) begin
                        sample <= adc_data;
                        state  <= ST_STORE;
                    end else if (cnt == '0) begin
                        sample      <= '0;
                        timeout_err <= 1'b1;
                        state       <= ST_STORE;
                    end else cnt <= cnt - 1'b1;
                ST_STORE: begin
                    state      <= ST_SW_HIGH;
                    switch_out <= 1'b1;
                    cnt        <= CW'(SW_HI - 1);
                end
                ST_SW_HIGH:
                    if (cnt == '0) begin
                        state      <= ST_SW_LOW;
                        switch_out <= 1'b0;
                        cnt        <= CW'(SW_LO - 1);
                    end else cnt <= cnt - 1'b1;
                ST_SW_LOW:
                    if (cnt == '0) begin
                        cnt <= CW'(SETTLE - 1);
                        if (last) begin
                            slot        <= '0;
                            frame_valid <= 1'b1;
                            frame_cnt   <= frame_cnt + 1'b1;
                            state       <= enable ? ST_SETTLE : ST_IDLE;
                        end else begin
                            slot  <= slot + 1'b1;
                            state <= ST_SETTLE;
                        end
                    end else cnt <= cnt - 1'b1;
                default: state <= ST_IDLE;
            endcase
        end
    mux_frame_buf #(.NCH(NCH), .DW(DW)) u_buf (
        .clk     (clk),
        .reset   (reset),
        .we      (state == ST_STORE),
        .wr_addr (slot),
        .wr_data (sample),
        .swap    (swap),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );
endmodule

// File: tb/tb_mux_frame_sampler.sv
// tb_mux_frame_sampler: directed bench with an ADC responder and a switcher channel model.
module tb_mux_frame_sampler;
    localparam int NCH = 18;
    logic clk, reset, enable, switch_out, adc_start, adc_done, frame_valid, timeout_err;
    logic [11:0] adc_data, rd_data;
    logic [4:0] slot, rd_addr;
    logic [15:0] frame_cnt;
    int n_tests, n_fail;
    int skip;
    logic [15:0] base;
    int adc_s;
    int cyc, last_start, sw_pulses, fv_pulses, starts, chan, chan_bad;
    int per_to [32];
    logic sw_q;
    int n0;

    mux_frame_sampler dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .switch_out  (switch_out),
        .adc_start   (adc_start),
        .adc_done    (adc_done),
        .adc_data    (adc_data),
        .slot        (slot),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_valid (frame_valid),
        .frame_cnt   (frame_cnt),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_slot(input int s, input int budget, input string tag);
        int i = 0;
        while (slot != 5'(s) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(slot), 32'(s));
    endtask

    task automatic wait_fv(input int budget, input string tag);
        int i = 0;
        while (!frame_valid && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(frame_valid), 1);
    endtask

    // ADC: answers 10 cycles after the start strobe with base+slot, silent on the skip slot.
    initial begin
        adc_done = 1'b0;
        adc_data = '0;
        forever begin
            @(negedge clk);
            if (reset && adc_start && int'(slot) != skip) begin
                adc_s = int'(slot);
                repeat (10) @(negedge clk);
                adc_data = 12'(base + 16'(adc_s));
                adc_done = 1'b1;
                @(negedge clk);
                adc_done = 1'b0;
                adc_data = '0;
            end
        end
    end

    // Switcher model: channel advances on each switch_out rising edge, cleared by reset.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            chan = 0;
            sw_q = 1'b0;
        end else begin
            if (switch_out && !sw_q) begin
                sw_pulses++;
                chan = (chan + 1) % NCH;
            end
            sw_q = switch_out;
            if (frame_valid) fv_pulses++;
            if (adc_start) begin
                starts++;
                if (chan != int'(slot)) chan_bad++;
                per_to[slot] = cyc - last_start;
                last_start = cyc;
            end
        end
    end

    initial begin
        reset = 1'b0;
        enable = 1'b0;
        rd_addr = '0;
        skip = 99;
        base = 16'h100;
        repeat (3) @(negedge clk);
        check("rst_switch_out", 32'(switch_out), 0);
        check("rst_adc_start", 32'(adc_start), 0);
        check("rst_slot", 32'(slot), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_frame_valid", 32'(frame_valid), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_no_start", 32'(starts), 0);
        check("idle_no_switch", 32'(sw_pulses), 0);
        // Frame 1: enable dropped mid-frame, frame still completes then idles.
        enable = 1'b1;
        wait_slot(9, 2000, "f1_reach_slot9");
        enable = 1'b0;
        wait_fv(2000, "f1_frame_valid");
        check("f1_frame_cnt", 32'(frame_cnt), 1);
        @(negedge clk);
        check("f1_fv_one_cycle", 32'(frame_valid), 0);
        n0 = starts;
        repeat (200) @(negedge clk);
        check("f1_idle_no_start", 32'(starts - n0), 0);
        check("f1_switch_low", 32'(switch_out), 0);
        check("f1_sw_pulses", 32'(sw_pulses), 18);
        check("f1_fv_pulses", 32'(fv_pulses), 1);
        check("f1_chan_wrap", 32'(chan), 0);
        check("f1_slot_period", 32'(per_to[1]), 84);
        check("f1_no_timeout", 32'(timeout_err), 0);
        for (int i = 0; i < NCH; i++) begin
            rd_addr = 5'(i);
            @(negedge clk);
            check($sformatf("f1_rd%0d", i), 32'(rd_data), 32'h100 + 32'(i));
        end
        rd_addr = 5'd18;
        @(negedge clk);
        check("rd_oob18", 32'(rd_data), 0);
        rd_addr = 5'd31;
        @(negedge clk);
        check("rd_oob31", 32'(rd_data), 0);
        // Frame 2: slot 5 times out; rd_addr 3 watched across the bank swap.
        base = 16'h200;
        skip = 5;
        rd_addr = 5'd3;
        enable = 1'b1;
        wait_slot(9, 4000, "f2_reach_slot9");
        enable = 1'b0;
        check("f2_old_before_swap", 32'(rd_data), 32'h103);
        wait_fv(4000, "f2_frame_valid");
        check("f2_swap_old", 32'(rd_data), 32'h103);
        @(negedge clk);
        check("f2_swap_new", 32'(rd_data), 32'h203);
        skip = 99;
        check("f2_timeout_err", 32'(timeout_err), 1);
        check("f2_timeout_period", 32'(per_to[6]), 64 + 1024 + 1 + 8);
        check("f2_frame_cnt", 32'(frame_cnt), 2);
        check("f2_sw_pulses", 32'(sw_pulses), 36);
        rd_addr = 5'd5;
        @(negedge clk);
        check("f2_rd5_timeout", 32'(rd_data), 0);
        rd_addr = 5'd4;
        @(negedge clk);
        check("f2_rd4", 32'(rd_data), 32'h204);
        rd_addr = 5'd6;
        @(negedge clk);
        check("f2_rd6", 32'(rd_data), 32'h206);
        // Frame 3: reset during slot 7 switch-high phase.
        base = 16'h300;
        enable = 1'b1;
        wait_slot(7, 2000, "f3_reach_slot7");
        for (int i = 0; i < 200 && !switch_out; i++) @(negedge clk);
        check("f3_in_sw_high", 32'(switch_out), 1);
        check("f3_timeout_sticky", 32'(timeout_err), 1);
        reset = 1'b0;
        #1;
        check("f3_rst_switch_out", 32'(switch_out), 0);
        check("f3_rst_frame_cnt", 32'(frame_cnt), 0);
        check("f3_rst_slot", 32'(slot), 0);
        check("f3_rst_timeout", 32'(timeout_err), 0);
        check("f3_rst_rd_data", 32'(rd_data), 0);
        @(negedge clk);
        reset = 1'b1;
        n0 = starts;
        for (int i = 0; i < 200 && starts == n0; i++) @(negedge clk);
        check("f3_restart_seen", 32'(starts - n0), 1);
        check("f3_restart_slot", 32'(slot), 0);
        wait_fv(3000, "f3_frame_valid");
        check("f3_frame_cnt", 32'(frame_cnt), 1);
        rd_addr = 5'd0;
        @(negedge clk);
        check("f3_rd0", 32'(rd_data), 32'h300);
        rd_addr = 5'd17;
        @(negedge clk);
        check("f3_rd17", 32'(rd_data), 32'h311);
        enable = 1'b0;
        check("chan_sync", 32'(chan_bad), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
